schmidl_cox_preamble_inserter: RTL and testbench

SCHMIDL_COX_PREAMBLE_INSERTER -- requirements
Module: schmidl_cox_preamble_inserter

---
 rtl/schmidl_cox_preamble_inserter.sv | 145 ++++++++++++++
 tb/tb_schmidl_cox_preamble_inserter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prefixes each payload frame with a Schmidl-Cox training symbol (two identical LFSR-driven halves).
// Optional zero-sample guard between preamble and payload when SC_PREAMBLE_GAP_EN is defined.
module schmidl_cox_preamble_inserter #(
    parameter int                 FFT_SIZE  = 1024,
    parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
    parameter logic [14:0]        LFSR_SEED = 15'h7FFF,
    parameter int                 GAP_LEN   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam int HALF = FFT_SIZE / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic signed [15:0] POS_AMP = AMPLITUDE;
    localparam logic signed [15:0] NEG_AMP = -AMPLITUDE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_A,
        S_PRE_B,
        S_PAYLOAD
`ifdef SC_PREAMBLE_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [14:0]    lfsr_q;
    logic [14:0]    lfsr_step;
    logic           half_done;
    logic [15:0]    pre_i;
    logic [15:0]    pre_q;

`ifdef SC_PREAMBLE_GAP_EN
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GW-1:0]  gap_cnt_q;
`endif

    assign lfsr_step = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    assign half_done = (cnt_q == CW'(HALF - 1));
    assign pre_i     = lfsr_q[0] ? NEG_AMP : POS_AMP;
    assign pre_q     = lfsr_q[1] ? NEG_AMP : POS_AMP;

    // Outputs decode only registered state, so they hold while stalled; payload is a pure passthrough.
    always_comb begin
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_tdata  = '0;
        i_tready = 1'b0;
        case (state_q)
            S_PRE_A, S_PRE_B: begin
                o_tvalid = 1'b1;
                o_tdata  = {pre_i, pre_q};
            end
`ifdef SC_PREAMBLE_GAP_EN
            S_GAP: o_tvalid = 1'b1;
`endif
            S_PAYLOAD: begin
                o_tvalid = i_tvalid;
                o_tlast  = i_tlast;
                o_tdata  = i_tdata;
                i_tready = o_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
`ifdef SC_PREAMBLE_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_tvalid) begin
                        state_q <= S_PRE_A;
                        cnt_q   <= '0;
                        lfsr_q  <= LFSR_SEED;
                    end
                end
                S_PRE_A: begin
                    if (o_tready) begin
                        if (half_done) begin
                            state_q <= S_PRE_B;
                            cnt_q   <= '0;
                            lfsr_q  <= LFSR_SEED;
                        end else begin
                            cnt_q  <= cnt_q + CW'(1);
                            lfsr_q <= lfsr_step;
                        end
                    end
                end
                S_PRE_B: begin
                    if (o_tready) begin
                        if (half_done) begin
                            cnt_q <= '0;
`ifdef SC_PREAMBLE_GAP_EN
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
`else
                            state_q <= S_PAYLOAD;
`endif
                        end else begin
                            cnt_q  <= cnt_q + CW'(1);
                            lfsr_q <= lfsr_step;
                        end
                    end
                end
`ifdef SC_PREAMBLE_GAP_EN
                S_GAP: begin
                    if (o_tready) begin
                        if (gap_cnt_q == GW'(GAP_LEN - 1)) begin
                            state_q <= S_PAYLOAD;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GW'(1);
                        end
                    end
                end
`endif
                S_PAYLOAD: begin
                    if (i_tvalid && o_tready && i_tlast) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Scoreboard bench: a frame-level reference model queues expected outputs, a negedge monitor checks them.
module tb_schmidl_cox_preamble_inserter;

    localparam int                 FFT  = 64;
    localparam int                 HALF = FFT / 2;
    localparam logic signed [15:0] AMP  = 16'sd8192;
    localparam logic [14:0]        SEED = 15'h7FFF;
    localparam int                 GAPN = 16;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;

    schmidl_cox_preamble_inserter #(
        .FFT_SIZE (FFT),
        .AMPLITUDE(AMP),
        .LFSR_SEED(SEED),
        .GAP_LEN  (GAPN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .i_tdata (i_tdata),
        .i_tlast (i_tlast),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .o_tdata (o_tdata),
        .o_tlast (o_tlast),
        .o_tvalid(o_tvalid),
        .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        first;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] cur_pay[$];
    int          start_q[$];
    int          last_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          hs_count = 0;
    bit          rnd_ready = 0;
    bit          drv_done = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: two copies of the same 32-sample LFSR run, optional zero guard, then the payload.
    task automatic push_expect();
        logic [14:0]        s;
        logic signed [15:0] iv, qv;
        for (int h = 0; h < 2; h++) begin
            s = SEED;
            for (int k = 0; k < HALF; k++) begin
                iv = s[0] ? -AMP : AMP;
                qv = s[1] ? -AMP : AMP;
                expq.push_back('{data: {iv, qv}, last: 1'b0, first: (h == 0 && k == 0)});
                s = {s[13:0], s[14] ^ s[13]};
            end
        end
`ifdef SC_PREAMBLE_GAP_EN
        for (int g = 0; g < GAPN; g++) expq.push_back('{data: 32'h0, last: 1'b0, first: 1'b0});
`endif
        for (int p = 0; p < cur_pay.size(); p++)
            expq.push_back('{data: cur_pay[p], last: (p == cur_pay.size() - 1), first: 1'b0});
    endtask

    task automatic send_frame(input int n, input bit bubbles);
        int t;
        drv_done = 0;
        cur_pay.delete();
        for (int i = 0; i < n; i++) cur_pay.push_back($urandom);
        push_expect();
        for (int i = 0; i < n; i++) begin
            if (bubbles) begin
                while ($urandom_range(0, 3) == 0) begin
                    i_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            i_tvalid = 1'b1;
            i_tdata  = cur_pay[i];
            i_tlast  = (i == n - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (i_tready && !reset && !clear) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                t++;
                if (t > 5000) break;
            end
            if (t > 5000) begin
                checks++;
                failures++;
                $display("FAIL input_handshake_timeout: got no i_tready expected handshake");
                break;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        drv_done = 1;
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() > 0 && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL output_drain_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1 o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pop on handshake, stability check while stalled.
    logic        stalled = 1'b0;
    logic [31:0] st_data;
    logic        st_last;
    always @(negedge clk) begin
        exp_t e;
        if (reset || clear) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_hold", {31'h0, o_tvalid, o_tlast, o_tdata}, {31'h0, 1'b1, st_last, st_data});
            end
            if (o_tvalid && o_tready) begin
                hs_count++;
                if (expq.size() == 0) begin
                    chk("unexpected_output", {31'h0, o_tlast, o_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("out_sample", {31'h0, o_tlast, o_tdata}, {31'h0, e.last, e.data});
                    if (e.first) start_q.push_back(cyc);
                    if (e.last) last_q.push_back(cyc);
                end
            end
            stalled = o_tvalid && !o_tready;
            st_data = o_tdata;
            st_last = o_tlast;
        end
    end

    initial begin
        int t;
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_o_tvalid", {63'h0, o_tvalid}, 64'h0);
        chk("reset_o_tlast", {63'h0, o_tlast}, 64'h0);
        chk("reset_i_tready", {63'h0, i_tready}, 64'h0);
        chk("reset_o_tdata", {32'h0, o_tdata}, 64'h0);
        @(posedge clk); #1;

        send_frame(10, 0);
        drain();

        rnd_ready = 1;
        send_frame(10, 0);
        drain();

        rnd_ready = 0;
        start_q.delete();
        last_q.delete();
        send_frame(10, 0);
        send_frame(10, 0);
        drain();
        if (start_q.size() >= 2 && last_q.size() >= 1)
            chk("b2b_restart_gap", 64'(start_q[1] - last_q[0]), 64'd2);
        else
            chk("b2b_frames_seen", 64'(start_q.size()), 64'd2);

        hs_count = 0;
        fork
            send_frame(10, 0);
        join_none
        t = 0;
        while (hs_count < 40 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pre_count_at_reset", 64'(hs_count), 64'd40);
        reset = 1'b1;
        expq.delete();
        push_expect();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_o_tvalid", {63'h0, o_tvalid}, 64'h0);
        chk("abort_o_tlast", {63'h0, o_tlast}, 64'h0);
        t = 0;
        while (!drv_done && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        drain();

        rnd_ready = 1;
        send_frame(1, 1);
        drain();

        repeat (6) send_frame($urandom_range(1, 20), 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
